// File: rtl/rv32i_defs.sv
// Shared RV32I definitions: operand width plus refill-side FSM and line types.
package rv32i_defs;

    localparam int OperandSize = 32;
    localparam int LineWords   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        COMMIT
    } refill_state_e;

    typedef logic [LineWords-1:0][OperandSize-1:0] line_t;

endpackage

// File: rtl/line_refill_memory.sv
// Line-granular backing memory: fixed-latency refill bursts and atomic write-backs.
// Optional `REFILL_CRITICAL_WORD_FIRST_EN starts refill bursts at the requested word.
module line_refill_memory
    import rv32i_defs::*;
#(
    parameter int WordsPerLine = LineWords,
    parameter int DepthWords   = 1024,
    parameter int Latency      = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [31:0]                         req_addr,
    input  logic [WordsPerLine*OperandSize-1:0] req_wdata,
    output logic                                resp_valid,
    output logic [OperandSize-1:0]              resp_data,
    output logic [$clog2(WordsPerLine)-1:0]     resp_beat,
    output logic                                resp_last,
    output logic                                wr_done
);

    localparam int AW = $clog2(DepthWords);
    localparam int OB = $clog2(WordsPerLine);
    localparam int LN = AW - OB;
    localparam int LW = (Latency > 1) ? $clog2(Latency) : 1;

    logic [OperandSize-1:0] r_mem [DepthWords];

    refill_state_e                      r_state;
    refill_state_e                      w_state_n;
    logic [LW-1:0]                      r_lat;
    logic [LW-1:0]                      w_lat_n;
    logic [OB-1:0]                      r_cnt;
    logic [OB-1:0]                      w_cnt_n;
    logic [OB-1:0]                      r_off;
    logic [OB-1:0]                      w_off_n;
    logic [OB-1:0]                      w_rd_off;
    logic [OB-1:0]                      w_start;
    logic [LN-1:0]                      r_line;
    logic                               r_write;
    logic [WordsPerLine*OperandSize-1:0] r_wdata;
    logic                               r_valid;
    logic                               r_last;
    logic                               r_done;
    logic [OperandSize-1:0]             r_data;
    logic                               w_valid_n;
    logic                               w_last_n;
    logic                               w_done_n;
    logic                               w_accept;
    logic                               w_we;
    logic                               w_rd;
    logic [OperandSize-1:0]             w_rd_data;
    logic                               w_unused_addr;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign w_start = req_addr[OB+1:2];
`else
    assign w_start = '0;
`endif

    // High address bits alias; byte offset is meaningless for word storage.
    assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[OB+1:0]};

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_valid;
    assign resp_data  = r_data;
    assign resp_beat  = r_off;
    assign resp_last  = r_last;
    assign wr_done    = r_done;
    assign w_rd_data  = r_mem[{r_line, w_rd_off}];

    always_comb begin
        w_state_n = r_state;
        w_lat_n   = r_lat;
        w_cnt_n   = r_cnt;
        w_off_n   = r_off;
        w_rd_off  = r_off;
        w_valid_n = 1'b0;
        w_last_n  = 1'b0;
        w_done_n  = 1'b0;
        w_accept  = 1'b0;
        w_we      = 1'b0;
        w_rd      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_state_n = WAIT;
                    w_lat_n   = LW'(Latency - 1);
                    w_cnt_n   = '0;
                    w_off_n   = w_start;
                end
            end
            WAIT: begin
                if (r_lat == '0) begin
                    if (r_write) begin
                        w_we      = 1'b1;
                        w_done_n  = 1'b1;
                        w_state_n = COMMIT;
                    end else begin
                        w_state_n = BURST;
                        w_valid_n = 1'b1;
                        w_rd      = 1'b1;
                    end
                end else begin
                    w_lat_n = r_lat - LW'(1);
                end
            end
            BURST: begin
                if (r_cnt == OB'(WordsPerLine - 1)) begin
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n   = r_cnt + OB'(1);
                    w_off_n   = r_off + OB'(1);
                    w_rd_off  = r_off + OB'(1);
                    w_valid_n = 1'b1;
                    w_rd      = 1'b1;
                    w_last_n  = (r_cnt == OB'(WordsPerLine - 2));
                end
            end
            COMMIT: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_lat   <= '0;
            r_cnt   <= '0;
            r_off   <= '0;
            r_line  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_n;
            r_lat   <= w_lat_n;
            r_cnt   <= w_cnt_n;
            r_off   <= w_off_n;
            r_valid <= w_valid_n;
            r_last  <= w_last_n;
            r_done  <= w_done_n;
            if (w_accept) begin
                r_line  <= req_addr[AW+1:OB+2];
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (w_rd) begin
                r_data <= w_rd_data;
            end
        end
    end

    // Storage is never reset; a reset before commit leaves w_we low.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < WordsPerLine; i++) begin
                r_mem[{r_line, OB'(i)}] <= r_wdata[i*OperandSize +: OperandSize];
            end
        end
    end

endmodule

// File: tb/tb_line_refill_memory.sv
// Scoreboard bench for line_refill_memory against a word-array reference model.
module tb_line_refill_memory;
    import rv32i_defs::*;

    localparam int W = 4;
    localparam int D = 1024;
    localparam int L = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [31:0]     req_addr = '0;
    logic [W*32-1:0] req_wdata = '0;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic [1:0]      resp_beat;
    logic            resp_last;
    logic            wr_done;

    line_refill_memory #(
        .WordsPerLine(W),
        .DepthWords  (D),
        .Latency     (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_beat (resp_beat),
        .resp_last (resp_last),
        .wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        int          beat;
        bit          last;
        int          at;
    } beat_t;

    beat_t       rq[$];
    int          wq[$];
    beat_t       mon_e;
    int          mon_w;
    logic [31:0] mdl [D];
    int          nchk = 0;
    int          nerr = 0;
    int          exp_acc = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_beat", 64'(resp_data), 64'hDEAD);
            end else begin
                mon_e = rq.pop_front();
                chk("beat_data", 64'(resp_data), 64'(mon_e.data));
                chk("beat_idx", 64'(resp_beat), 64'(mon_e.beat));
                chk("beat_last", 64'(resp_last), 64'(mon_e.last));
                chk("beat_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
        if (wr_done === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_wr_done", 64'(cyc), 64'hDEAD);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_done_cycle", 64'(cyc), 64'(mon_w));
            end
        end
    end

    task automatic push_expect(input bit wr, input logic [31:0] addr,
                               input logic [W*32-1:0] wd, input int a);
        int idx, base, st, off;
        idx  = int'((addr >> 2) % D);
        base = idx - (idx % W);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        st = idx % W;
`else
        st = 0;
`endif
        if (wr) begin
            for (int i = 0; i < W; i++) mdl[base+i] = wd[i*32 +: 32];
            wq.push_back(a + L);
        end else begin
            for (int i = 0; i < W; i++) begin
                beat_t b;
                off    = (st + i) % W;
                b.data = mdl[base+off];
                b.beat = off;
                b.last = (i == W - 1);
                b.at   = a + L + i;
                rq.push_back(b);
            end
        end
    endtask

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic issue(input bit wr, input logic [31:0] addr,
                         input logic [W*32-1:0] wd, output int a);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        a = -1;
        for (int k = 0; k < 200 && a < 0; k++) begin
            if (req_ready === 1'b1) begin
                a = cyc + 1;
                push_expect(wr, addr, wd, a);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (a < 0) begin
            chk("accept_timeout", 64'(0), 64'(1));
            exp_acc = -1;
        end else begin
            if (exp_acc >= 0) chk("accept_cycle", 64'(a), 64'(exp_acc));
            exp_acc = wr ? a + L + 2 : a + L + W + 1;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
        exp_acc = -1;
    endtask

    function automatic logic [W*32-1:0] mkline(input logic [31:0] seed);
        logic [W*32-1:0] l;
        for (int i = 0; i < W; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    logic [W*32-1:0] line_a;
    logic [W*32-1:0] rnd;
    logic [31:0]     saved [W];
    logic [31:0]     addr;
    int              a;
    int              lines [8];
    bit              written [8];
    int              j;

    initial begin
        line_a = mkline(32'hA0A0_0000);
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(resp_valid), 64'(0));
        chk("rst_last", 64'(resp_last), 64'(0));
        chk("rst_wr_done", 64'(wr_done), 64'(0));
        chk("rst_data", 64'(resp_data), 64'(0));
        chk("rst_beat", 64'(resp_beat), 64'(0));
        #1 rst = 1'b1;
        #1 chk("rst_ready", 64'(req_ready), 64'(1));
        @(negedge clk);

        issue(1'b1, 32'h100, line_a, a);
        issue(1'b0, 32'h100, '0, a);
        issue(1'b0, 32'h108, {W{32'h5555_AAAA}}, a);
        issue(1'b1, 32'h1000, mkline(32'hB0B0_0000), a);
        issue(1'b0, 32'h0, '0, a);
        issue(1'b0, 32'h10C, '0, a);

        idle(10);
        issue(1'b0, 32'h100, '0, a);
        for (int k = 0; k < 50 && cyc != a + L + 2; k++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(resp_valid), 64'(0));
        chk("midrst_last", 64'(resp_last), 64'(0));
        chk("midrst_data", 64'(resp_data), 64'(0));
        chk("midrst_beat", 64'(resp_beat), 64'(0));
        rq.delete();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("midrst_ready", 64'(req_ready), 64'(1));
        exp_acc = -1;
        issue(1'b0, 32'h104, '0, a);

        idle(10);
        for (int i = 0; i < W; i++) saved[i] = mdl[64+i];
        issue(1'b1, 32'h100, mkline(32'hC0C0_0000), a);
        #2 rst = 1'b0;
        wq.delete();
        for (int i = 0; i < W; i++) mdl[64+i] = saved[i];
        @(negedge clk);
        chk("wrrst_done", 64'(wr_done), 64'(0));
        #1 rst = 1'b1;
        exp_acc = -1;
        issue(1'b0, 32'h100, '0, a);

        for (int i = 0; i < 8; i++) begin
            lines[i]   = int'($urandom_range(0, D / W - 1));
            written[i] = 1'b0;
        end
        for (int n = 0; n < 60; n++) begin
            j    = int'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_F000) | 32'(lines[j] * W * 4)
                 | 32'($urandom_range(0, W - 1) * 4) | 32'($urandom_range(0, 3));
            for (int i = 0; i < W; i++) rnd[i*32 +: 32] = $urandom;
            if (!written[j] || $urandom_range(0, 2) == 0) begin
                issue(1'b1, addr, rnd, a);
                written[j] = 1'b1;
            end else begin
                issue(1'b0, addr, rnd, a);
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 4)));
        end

        idle(30);
        chk("read_queue_drained", 64'(rq.size()), 64'(0));
        chk("write_queue_drained", 64'(wq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
